// File: rtl/spio_spinnaker_link_packet_deserializer.sv
// SpiNNaker link packet deserializer: 2-of-7 flits in, 40/72-bit packets out.
// Assembles nibbles, checks length/symbol/odd parity, drops bad packets.
module spio_spinnaker_link_packet_deserializer (
  input  logic        CLK_IN,
  input  logic        RESET_IN,
  input  logic [6:0]  flt_data_2of7,
  input  logic        flt_vld,
  output logic        flt_rdy,
  output logic [71:0] pkt_data,
  output logic        pkt_long,
  output logic        pkt_vld,
  input  logic        pkt_rdy,
  output logic        err_sym,
  output logic        err_len,
  output logic        err_par
);

  typedef enum logic {ASSEMBLE, DROP} state_t;

  state_t      r_state;
  state_t      w_state_n;
  logic [4:0]  r_cnt;
  logic [4:0]  w_cnt_n;
  logic [71:0] r_asm;
  logic [71:0] w_asm_n;
  logic        r_vld;
  logic        r_long;
  logic [71:0] r_data;
  logic        r_esym;
  logic        r_elen;
  logic        r_epar;
  logic        w_esym;
  logic        w_elen;
  logic        w_epar;
  logic        w_done;
  logic        w_acc;
  logic [3:0]  w_nib;
  logic        w_eop;
  logic        w_bad;
  logic [6:0]  w_sh;

  assign flt_rdy  = !(r_vld && !pkt_rdy);
  assign w_acc    = flt_vld && flt_rdy;
  assign w_sh     = {r_cnt, 2'b00};
  assign pkt_vld  = r_vld;
  assign pkt_long = r_long;
  assign pkt_data = r_data;
  assign err_sym  = r_esym;
  assign err_len  = r_elen;
  assign err_par  = r_epar;

  // 2-of-7 symbol decode
  always_comb begin
    w_nib = 4'h0;
    w_eop = 1'b0;
    w_bad = 1'b0;
    unique case (flt_data_2of7)
      7'h11: w_nib = 4'h0;
      7'h12: w_nib = 4'h1;
      7'h14: w_nib = 4'h2;
      7'h18: w_nib = 4'h3;
      7'h21: w_nib = 4'h4;
      7'h22: w_nib = 4'h5;
      7'h24: w_nib = 4'h6;
      7'h28: w_nib = 4'h7;
      7'h41: w_nib = 4'h8;
      7'h42: w_nib = 4'h9;
      7'h44: w_nib = 4'hA;
      7'h48: w_nib = 4'hB;
      7'h03: w_nib = 4'hC;
      7'h06: w_nib = 4'hD;
      7'h0C: w_nib = 4'hE;
      7'h09: w_nib = 4'hF;
      7'h60: w_eop = 1'b1;
      default: w_bad = 1'b1;
    endcase
  end

  // next state, assembly update and error detection
  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_asm_n   = r_asm;
    w_esym    = 1'b0;
    w_elen    = 1'b0;
    w_epar    = 1'b0;
    w_done    = 1'b0;
    if (w_acc) begin
      unique case (r_state)
        ASSEMBLE: begin
          if (w_bad) begin
            w_esym    = 1'b1;
            w_state_n = DROP;
            w_cnt_n   = '0;
            w_asm_n   = '0;
          end else if (w_eop) begin
            w_cnt_n = '0;
            w_asm_n = '0;
            if (r_cnt == 5'd10 || r_cnt == 5'd18) begin
              if (^r_asm) w_done = 1'b1;
              else        w_epar = 1'b1;
            end else begin
              w_elen = 1'b1;
            end
          end else if (r_cnt == 5'd18) begin
            w_elen    = 1'b1;
            w_state_n = DROP;
            w_cnt_n   = '0;
            w_asm_n   = '0;
          end else begin
            w_asm_n = r_asm | ({68'd0, w_nib} << w_sh);
            w_cnt_n = r_cnt + 5'd1;
          end
        end
        DROP: begin
          if (w_eop) w_state_n = ASSEMBLE;
          w_cnt_n = '0;
          w_asm_n = '0;
        end
        default: w_state_n = ASSEMBLE;
      endcase
    end
  end

  // assembly state and registered error pulses
  always_ff @(posedge CLK_IN or negedge RESET_IN) begin
    if (!RESET_IN) begin
      r_state <= ASSEMBLE;
      r_cnt   <= '0;
      r_asm   <= '0;
      r_esym  <= 1'b0;
      r_elen  <= 1'b0;
      r_epar  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_asm   <= w_asm_n;
      r_esym  <= w_esym;
      r_elen  <= w_elen;
      r_epar  <= w_epar;
    end
  end

  // output packet register; reloads without a bubble on accept
  always_ff @(posedge CLK_IN or negedge RESET_IN) begin
    if (!RESET_IN) begin
      r_vld  <= 1'b0;
      r_long <= 1'b0;
      r_data <= '0;
    end else if (w_done) begin
      r_vld  <= 1'b1;
      r_long <= (r_cnt == 5'd18);
      r_data <= r_asm;
    end else if (r_vld && pkt_rdy) begin
      r_vld  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spio_spinnaker_link_packet_deserializer.sv
// Randomized bench for the SpiNNaker link packet deserializer.
// Compares every cycle against a queue-based packet reference model.
module tb_spio_spinnaker_link_packet_deserializer;

  logic        CLK_IN = 1'b0;
  logic        RESET_IN;
  logic [6:0]  flt_data_2of7;
  logic        flt_vld;
  logic        flt_rdy;
  logic [71:0] pkt_data;
  logic        pkt_long;
  logic        pkt_vld;
  logic        pkt_rdy;
  logic        err_sym;
  logic        err_len;
  logic        err_par;

  spio_spinnaker_link_packet_deserializer dut (
    .CLK_IN        (CLK_IN),
    .RESET_IN      (RESET_IN),
    .flt_data_2of7 (flt_data_2of7),
    .flt_vld       (flt_vld),
    .flt_rdy       (flt_rdy),
    .pkt_data      (pkt_data),
    .pkt_long      (pkt_long),
    .pkt_vld       (pkt_vld),
    .pkt_rdy       (pkt_rdy),
    .err_sym       (err_sym),
    .err_len       (err_len),
    .err_par       (err_par)
  );

  always #5 CLK_IN = ~CLK_IN;

  logic [6:0] codes [16] = '{
    7'h11, 7'h12, 7'h14, 7'h18,
    7'h21, 7'h22, 7'h24, 7'h28,
    7'h41, 7'h42, 7'h44, 7'h48,
    7'h03, 7'h06, 7'h0C, 7'h09
  };

  int n_chk  = 0;
  int n_fail = 0;
  int vld_pct = 100;
  int rdy_pct = 100;
  int n_pkts  = 0;

  logic [6:0]  stream [$];
  int          m_nibs [$];
  bit          m_drop;
  logic        m_vld, m_long, m_es, m_el, m_ep;
  logic [71:0] m_data;

  task automatic check(string tag, logic [71:0] got,
                       logic [71:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic int dec(logic [6:0] s);
    if (s == 7'h60) return 16;
    for (int i = 0; i < 16; i++)
      if (codes[i] == s) return i;
    return -1;
  endfunction

  task automatic model_clear();
    m_nibs.delete();
    m_drop = 0;
    m_vld  = 0;
    m_long = 0;
    m_data = '0;
    m_es   = 0;
    m_el   = 0;
    m_ep   = 0;
  endtask

  task automatic model_tick();
    bit          acc;
    int          s;
    int          n;
    logic [71:0] d;
    acc = flt_vld && !(m_vld && !pkt_rdy);
    m_es = 0;
    m_el = 0;
    m_ep = 0;
    if (m_vld && pkt_rdy) m_vld = 0;
    if (!acc) return;
    void'(stream.pop_front());
    s = dec(flt_data_2of7);
    if (m_drop) begin
      if (s == 16) m_drop = 0;
      return;
    end
    if (s < 0) begin
      m_es = 1;
      m_drop = 1;
      m_nibs.delete();
    end else if (s == 16) begin
      n = m_nibs.size();
      if (n == 10 || n == 18) begin
        d = '0;
        for (int k = 0; k < n; k++)
          d = d | (72'(m_nibs[k]) << (4 * k));
        if (^d) begin
          m_vld  = 1;
          m_data = d;
          m_long = (n == 18);
          n_pkts++;
        end else begin
          m_ep = 1;
        end
      end else begin
        m_el = 1;
      end
      m_nibs.delete();
    end else if (m_nibs.size() == 18) begin
      m_el = 1;
      m_drop = 1;
      m_nibs.delete();
    end else begin
      m_nibs.push_back(s);
    end
  endtask

  task automatic step();
    @(posedge CLK_IN);
    #1;
    flt_vld = RESET_IN && stream.size() > 0 &&
              ($urandom % 100) < vld_pct;
    flt_data_2of7 = flt_vld ? stream[0] : 7'($urandom);
    pkt_rdy = ($urandom % 100) < rdy_pct;
    @(negedge CLK_IN);
    check("flt_rdy", 72'(flt_rdy), 72'(!(m_vld && !pkt_rdy)));
    check("pkt_vld", 72'(pkt_vld), 72'(m_vld));
    check("err_sym", 72'(err_sym), 72'(m_es));
    check("err_len", 72'(err_len), 72'(m_el));
    check("err_par", 72'(err_par), 72'(m_ep));
    if (m_vld || !RESET_IN) begin
      check("pkt_data", pkt_data, m_data);
      check("pkt_long", 72'(pkt_long), 72'(m_long));
    end
    if (RESET_IN) model_tick();
  endtask

  task automatic run_until_empty(int bound);
    int c = 0;
    while (stream.size() > 0 && c < bound) begin
      step();
      c++;
    end
    check("drain_timeout", 72'(stream.size()), 72'd0);
    repeat (4) step();
  endtask

  task automatic push_nibs(int n);
    for (int k = 0; k < n; k++)
      stream.push_back(codes[$urandom % 16]);
  endtask

  task automatic push_pkt(bit lng, bit good);
    int          n;
    int          nb [$];
    logic [71:0] d;
    n = lng ? 18 : 10;
    d = '0;
    for (int k = 0; k < n; k++) begin
      nb.push_back(int'($urandom % 16));
      d = d | (72'(nb[k]) << (4 * k));
    end
    if ((^d) != good) nb[0] = nb[0] ^ 1;
    for (int k = 0; k < n; k++) stream.push_back(codes[nb[k]]);
    stream.push_back(7'h60);
  endtask

  function automatic logic [6:0] illegal_sym();
    logic [6:0] s;
    do s = 7'($urandom); while (dec(s) != -1);
    return s;
  endfunction

  task automatic reset_pulse();
    @(posedge CLK_IN);
    #1;
    RESET_IN = 1'b0;
    flt_vld  = 1'b0;
    stream.delete();
    model_clear();
    repeat (3) step();
    RESET_IN = 1'b1;
  endtask

  initial begin
    int kind;
    int n;
    RESET_IN = 1'b0;
    flt_vld = 1'b0;
    flt_data_2of7 = '0;
    pkt_rdy = 1'b0;
    model_clear();
    repeat (3) step();
    RESET_IN = 1'b1;

    stream.push_back(7'h12);
    repeat (9) stream.push_back(7'h11);
    stream.push_back(7'h60);
    run_until_empty(100);

    stream.push_back(7'h12);
    repeat (17) stream.push_back(7'h11);
    stream.push_back(7'h60);
    stream.push_back(7'h12);
    repeat (16) stream.push_back(7'h11);
    stream.push_back(7'h14);
    stream.push_back(7'h60);
    run_until_empty(100);

    stream.push_back(7'h12);
    repeat (3) stream.push_back(7'h11);
    stream.push_back(7'h7F);
    repeat (5) stream.push_back(7'h11);
    stream.push_back(7'h60);
    push_pkt(0, 1);
    run_until_empty(100);

    push_nibs(4);
    stream.push_back(7'h60);
    stream.push_back(7'h60);
    push_nibs(19);
    stream.push_back(7'h60);
    push_pkt(0, 1);
    run_until_empty(200);

    rdy_pct = 0;
    push_pkt(0, 1);
    push_pkt(1, 1);
    repeat (40) step();
    check("bp_not_consumed", 72'(stream.size() > 0), 72'd1);
    rdy_pct = 100;
    run_until_empty(200);

    push_nibs(5);
    run_until_empty(100);
    reset_pulse();
    n = n_pkts;
    push_pkt(0, 1);
    run_until_empty(100);
    check("reset_one_pkt", 72'(n_pkts - n), 72'd1);

    for (int i = 0; i < 300; i++) begin
      vld_pct = 40 + int'($urandom % 61);
      rdy_pct = 20 + int'($urandom % 81);
      kind = int'($urandom % 8);
      case (kind)
        0, 1, 2: push_pkt(0, 1);
        3, 4:    push_pkt(1, 1);
        5:       push_pkt($urandom % 2, 0);
        6: begin
          push_nibs(int'($urandom % 12));
          stream.push_back(illegal_sym());
          push_nibs(int'($urandom % 6));
          stream.push_back(7'h60);
        end
        default: begin
          n = int'($urandom % 21);
          if (n == 10 || n == 18) n++;
          push_nibs(n);
          stream.push_back(7'h60);
        end
      endcase
      if (i % 8 == 0) run_until_empty(2000);
    end
    run_until_empty(20000);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/spio_spinnaker_link_packet_deserializer.md
SPIO_SPINNAKER_LINK_PACKET_DESERIALIZER -- requirements
Module: spio_spinnaker_link_packet_deserializer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: CLK_IN clocks all state, and RESET_IN low clears all state immediately.
REQ-002 CLK_IN  in  1  system clock.
REQ-003 RESET_IN  in  1  asynchronous active-low reset.
REQ-004 flt_data_2of7  in  7  rtz 2-of-7 flit from the upstream async-to-sync FIFO.
REQ-005 flt_vld  in  1  flit valid.
REQ-006 flt_rdy  out  1  ready to accept a flit.
REQ-007 pkt_data  out  72  assembled packet; bits [39:0] for short packets, bits [71:40] zero.
REQ-008 pkt_long  out  1  1 = 72-bit packet, 0 = 40-bit packet.
REQ-009 pkt_vld  out  1  packet valid.
REQ-010 pkt_rdy  in  1  downstream accepts packet.
REQ-011 err_sym  out  1  one-cycle pulse: illegal symbol received.
REQ-012 err_len  out  1  one-cycle pulse: EOP at illegal nibble count, or nibble overrun.
REQ-013 err_par  out  1  one-cycle pulse: parity failure.

Function
REQ-014 A flit SHALL be accepted only in a cycle with flt_vld=1 and flt_rdy=1.
REQ-015 flt_rdy SHALL be combinational and equal !(pkt_vld && !pkt_rdy).
REQ-016 Symbol decode SHALL map 0x11,0x12,0x14,0x18,0x21,0x22,0x24,0x28,0x41,0x42,0x44,0x48,0x03,0x06,0x0C,0x09 to nibbles 0x0 through 0xF respectively, and 0x60 to EOP.
REQ-017 Any other 7-bit value SHALL be an illegal symbol.
REQ-018 The state machine SHALL have two states: ASSEMBLE (reset state) and DROP.
REQ-019 In ASSEMBLE, the k-th accepted nibble (k=0..17) SHALL be written to assembly bits [4k+3:4k], and the 5-bit nibble count SHALL increment.
REQ-020 In ASSEMBLE, the nibble count SHALL be 0 and the assembly register cleared after every EOP, error, or reset.
REQ-021 EOP accepted in ASSEMBLE with count 10 SHALL complete a short packet; with count 18, a long packet.
REQ-022 EOP accepted in ASSEMBLE with any other count (including 0) SHALL discard the packet, pulse err_len, and stay in ASSEMBLE.
REQ-023 A 19th data nibble in ASSEMBLE SHALL pulse err_len and move the state machine to DROP.
REQ-024 An illegal symbol in ASSEMBLE SHALL pulse err_sym and move the state machine to DROP.
REQ-025 In DROP, all symbols SHALL be discarded without further error pulses, and an accepted EOP SHALL return the state machine to ASSEMBLE with count 0.
REQ-026 A completed packet SHALL pass parity only if the XOR over its 40 or 72 bits equals 1 (odd parity).
REQ-027 A parity failure SHALL discard the packet and pulse err_par.
REQ-028 If EOP completing a good packet is accepted in cycle N, then in cycle N+1 pkt_vld SHALL be 1, pkt_data and pkt_long SHALL be valid, and the upper 32 bits SHALL be zero for short packets.
REQ-029 pkt_data and pkt_long SHALL be stable while pkt_vld=1 and pkt_rdy=0.
REQ-030 pkt_vld SHALL fall after a cycle with pkt_vld=1 and pkt_rdy=1, unless a new good packet completes in that same cycle; in that case the output register SHALL reload and pkt_vld SHALL stay 1 (no bubble).
REQ-031 Error pulses SHALL be registered and SHALL assert in cycle N+1 for the offending flit accepted in cycle N.
REQ-032 At most one error pulse SHALL assert per cycle.

Reset
REQ-033 While RESET_IN=0, the block SHALL force pkt_vld=0, err_sym=0, err_len=0, err_par=0, pkt_data=0, pkt_long=0, state=ASSEMBLE, and count=0.
REQ-034 While RESET_IN=0, flt_rdy SHALL read 1 per REQ-015.
REQ-035 Reset asserted mid-packet or with a pending output packet SHALL discard all partial and held data.
REQ-036 After reset release, the first accepted nibble SHALL be treated as nibble 0.

Verification
REQ-037 Short good packet: flits 0x12, 0x11 x9, 0x60 -> pkt_vld=1 one cycle after EOP, pkt_data=0x...0000000001, pkt_long=0, no error pulses.
REQ-038 Long good packet: 0x12, 0x11 x17, 0x60 -> pkt_data=0x...01, pkt_long=1; flipping any one nibble to even parity -> no pkt_vld, err_par pulses once.
REQ-039 Illegal symbol: 0x12, 0x11 x3, 0x7F, 0x11 x5, 0x60 -> err_sym pulse after 0x7F, no packet; the following good short packet is delivered intact.
REQ-040 Length errors: EOP after 4 nibbles -> err_len, back to ASSEMBLE; 19 nibbles -> err_len after the 19th, the following EOP produces no packet.
REQ-041 Backpressure: pkt_rdy=0 with a held packet -> flt_rdy=0, data stable, upstream flits not consumed; pkt_rdy=1 with a second EOP in the same cycle -> back-to-back delivery with pkt_vld continuously 1.
REQ-042 Reset mid-packet: RESET_IN low after 5 nibbles, then a full good short packet -> exactly one packet delivered, with correct data.
